// File: rtl/coalescing_store_buffer.sv
// In-order store buffer with byte-merged load forwarding.
// Define SB_COALESCE_EN to merge same-word stores into the youngest non-head entry.
module coalescing_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_valid,
    input  logic [AW-1:0]              enq_addr,
    input  logic [31:0]                enq_data,
    input  logic [3:0]                 enq_byte_en,
    output logic                       enq_ready,
    input  logic                       lookup_valid,
    input  logic [AW-1:0]              lookup_addr,
    output logic                       lookup_hit,
    output logic [31:0]                lookup_data,
    output logic [3:0]                 lookup_byte_en,
    output logic                       drain_valid,
    input  logic                       drain_ready,
    output logic [AW-1:0]              drain_addr,
    output logic [31:0]                drain_data,
    output logic [3:0]                 drain_byte_en,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       stall_pipeline
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = AW - 2;

    logic [TW-1:0] tag_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          coal;
    logic          accept;
    logic          alloc;
    logic [PW-1:0] idx;
    logic          unused_lsbs;

    assign unused_lsbs = ^{enq_addr[1:0], lookup_addr[1:0]};

    assign count          = cnt;
    assign empty          = (cnt == '0);
    assign full           = (cnt == CW'(DEPTH));
    assign drain_valid    = !empty;
    assign drain_addr     = {tag_q[head], 2'b00};
    assign drain_data     = data_q[head];
    assign drain_byte_en  = be_q[head];
    assign pop            = drain_valid && drain_ready;

`ifdef SB_COALESCE_EN
    logic [PW-1:0] young;
    assign young = tail - PW'(1);
    // With one entry the youngest is the head, which may be mid-transfer
    assign coal = enq_valid && (cnt > CW'(1))
                  && (tag_q[young] == enq_addr[AW-1:2]);
`else
    assign coal = 1'b0;
`endif

    assign enq_ready      = !flush && (!full || coal || pop);
    assign accept         = enq_valid && enq_ready;
    assign alloc          = accept && !coal;
    assign stall_pipeline = enq_valid && !enq_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (pop)
                head <= head + PW'(1);
            if (alloc) begin
                tag_q[tail]  <= enq_addr[AW-1:2];
                data_q[tail] <= enq_data;
                be_q[tail]   <= enq_byte_en;
                tail         <= tail + PW'(1);
            end
`ifdef SB_COALESCE_EN
            if (accept && coal) begin
                for (int l = 0; l < 4; l++)
                    if (enq_byte_en[l])
                        data_q[young][8*l +: 8] <= enq_data[8*l +: 8];
                be_q[young] <= be_q[young] | enq_byte_en;
            end
`endif
            cnt <= cnt + CW'(alloc) - CW'(pop);
        end
    end

    // Walk oldest to youngest so younger bytes override older ones
    always_comb begin
        lookup_data    = '0;
        lookup_byte_en = '0;
        idx            = '0;
        if (lookup_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + PW'(k);
                if (CW'(k) < cnt && tag_q[idx] == lookup_addr[AW-1:2]) begin
                    for (int l = 0; l < 4; l++) begin
                        if (be_q[idx][l]) begin
                            lookup_byte_en[l]       = 1'b1;
                            lookup_data[8*l +: 8]   = data_q[idx][8*l +: 8];
                        end
                    end
                end
            end
        end
    end

    assign lookup_hit = lookup_valid && (|lookup_byte_en);
endmodule
